// File: rtl/csla_iter_add32_if.sv
// csla_iter_add32_if: start/done request bus for the iterative adder; CSLA_OVF_EN adds ovf.
interface csla_iter_add32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSLA_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/csla_iter_add32.sv
// csla_iter_add32: iterative adder reusing one 4-bit carry-select slice per clock.
// Define CSLA_OVF_EN to add a registered signed-overflow flag.
module csla_iter_add32 #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  csla_iter_add32_if.slave bus
);
  localparam int G  = WIDTH / 4;
  localparam int IW = (G > 1) ? $clog2(G) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, work, work_nxt, sum_q;
  logic             carry, cout_q;
  logic [IW-1:0]    idx;
  logic [3:0]       ga, gb, s0, s1, gs;
  logic             c0, c1, gc, last, accept;
`ifdef CSLA_OVF_EN
  logic             ovf_q;
`endif
  assign last   = idx == IW'(G - 1);
  assign accept = bus.start && state != RUN;
  // Carry-select slice: RCA with carry-in 0, BEC supplies the +1 variant.
  always_comb begin
    ga = op_a[4*idx +: 4];
    gb = op_b[4*idx +: 4];
    {c0, s0} = {1'b0, ga} + {1'b0, gb};
    s1 = s0 + 4'd1;
    c1 = c0 | (&s0);
    gs = carry ? s1 : s0;
    gc = carry ? c1 : c0;
    work_nxt = work;
    work_nxt[4*idx +: 4] = gs;
  end
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = last ? DONE : RUN;
    else state_nxt = bus.start ? RUN : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      work   <= '0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef CSLA_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.b;
      carry <= bus.cin;
      work  <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      work  <= work_nxt;
      carry <= gc;
      idx   <= last ? '0 : idx + IW'(1);
      if (last) begin
        sum_q  <= work_nxt;
        cout_q <= gc;
`ifdef CSLA_OVF_EN
        ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef CSLA_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_csla_iter_add32.sv
// tb_csla_iter_add32: scoreboard bench for csla_iter_add32; honours CSLA_OVF_EN.
module tb_csla_iter_add32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  typedef struct {logic [31:0] s; logic c; logic o;} exp_t;
  exp_t q[$];
  csla_iter_add32_if #(.WIDTH(32)) bus ();
  csla_iter_add32 #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t e;
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (a[31] == b[31]) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.start = 1'b1;
    q.push_back(model(a, b, cin));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int k, output int nb);
    k = 0;
    nb = 0;
    while (bus.done !== 1'b1 && k < 30) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h want all zero", bus.busy, bus.done, bus.cout, bus.sum);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] ta[6];
    logic [31:0] tb_[6];
    logic        tc[6];
    int          k, nb;
    exp_t        e;
    ta = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, $urandom, $urandom};
    tb_ = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000, $urandom, $urandom};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb_[i], tc[i]);
      wait_done(k, nb);
      e = q.pop_front();
      total += 4;
      if (k !== 8) begin
        bad++;
        $display("FAIL basic_latency[%0d] got %0d edges want 8", i, k);
      end
      if (nb !== 8) begin
        bad++;
        $display("FAIL basic_busy[%0d] got %0d busy cycles want 8", i, nb);
      end
      if (bus.sum !== e.s) begin
        bad++;
        $display("FAIL basic_sum[%0d] got %h want %h", i, bus.sum, e.s);
      end
      if (bus.cout !== e.c) begin
        bad++;
        $display("FAIL basic_cout[%0d] got %b want %b", i, bus.cout, e.c);
      end
`ifdef CSLA_OVF_EN
      total++;
      if (bus.ovf !== e.o) begin
        bad++;
        $display("FAIL basic_ovf[%0d] got %b want %b", i, bus.ovf, e.o);
      end
`endif
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL basic_idle[%0d] got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_ignore_start;
    int   k, nb, extra;
    exp_t e;
    drive(32'h11111111, 32'h22222222, 1'b0);
    repeat (3) @(negedge clk);
    bus.a = 32'h12345678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k, nb);
    e = q.pop_front();
    total += 2;
    if (bus.sum !== e.s) begin
      bad++;
      $display("FAIL ignore_sum got %h want %h", bus.sum, e.s);
    end
    if (k !== 4) begin
      bad++;
      $display("FAIL ignore_latency got %0d more edges want 4", k);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignore_extra_done got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int   k, nb;
    exp_t e;
    drive(32'hDEADBEEF, 32'h01010101, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== 35'd0) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b done=%b cout=%b sum=%h want all zero", bus.busy, bus.done, bus.cout, bus.sum);
    end
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    drive(32'h00000003, 32'h00000004, 1'b0);
    wait_done(k, nb);
    e = q.pop_front();
    total += 2;
    if (k !== 8) begin
      bad++;
      $display("FAIL abort_latency got %0d edges want 8", k);
    end
    if (bus.sum !== e.s) begin
      bad++;
      $display("FAIL abort_sum got %h want %h", bus.sum, e.s);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int   k, nb, g;
    exp_t e;
    @(negedge clk);
    bus.a = 32'hA5A5A5A5;
    bus.b = 32'h5A5A5A5A;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    q.push_back(model(bus.a, bus.b, bus.cin));
    q.push_back(model(bus.a, bus.b, bus.cin));
    @(negedge clk);
    wait_done(k, nb);
    e = q.pop_front();
    total += 3;
    if (k !== 8) begin
      bad++;
      $display("FAIL b2b_latency got %0d edges want 8", k);
    end
    if (bus.sum !== e.s || bus.cout !== e.c) begin
      bad++;
      $display("FAIL b2b_first got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, e.s, e.c);
    end
    @(negedge clk);
    g = 1;
    while (bus.done !== 1'b1 && g < 30) begin
      @(negedge clk);
      g++;
    end
    bus.start = 1'b0;
    if (g !== 9) begin
      bad++;
      $display("FAIL b2b_gap got %0d cycles want 9", g);
    end
    e = q.pop_front();
    total++;
    if (bus.sum !== e.s || bus.cout !== e.c) begin
      bad++;
      $display("FAIL b2b_second got sum=%h cout=%b want sum=%h cout=%b", bus.sum, bus.cout, e.s, e.c);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    #2;
    test_reset;
    test_basic;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
